pipe_issue_ctrl: RTL and testbench

In-order issue controller for the 4-stage pipeline CPU. It sits between the decode (ID) latch and the execute stage. Each cycle it decides whether the decoded instruction issues, or the front end stalls and a NOP bubble goes into EX. A per-register scoreboard resolves RAW/WAW hazards on the 8-entry register file, and a run/drain/halt state machine sequences program start and stop.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_scoreboard.sv | 64 ++++++
 rtl/pipe_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcodes, issue-state enum and register-count default for the issue controller
package pipe_pkg;

    localparam int NREGS_DEF = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } issue_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register result-latency counters with busy lookup
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   set_i, set_idx_i         load RESULT_LAT into the counter of set_idx_i
//   rs/rt/rd_idx_i           lookup indices
//   busy_rs/rt/rd_o          looked-up register has a result in flight
//   pending_o                one bit per register, counter nonzero
module hazard_scoreboard #(
    parameter int NREGS      = 8,
    parameter int RESULT_LAT = 2,
    parameter int CNT_W      = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             set_i,
    input  logic [3:0]       set_idx_i,
    input  logic [3:0]       rs_idx_i,
    input  logic [3:0]       rt_idx_i,
    input  logic [3:0]       rd_idx_i,
    output logic             busy_rs_o,
    output logic             busy_rt_o,
    output logic             busy_rd_o,
    output logic [NREGS-1:0] pending_o
);

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];

    // A fresh write wins over the decrement of the same entry.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (set_i && (set_idx_i == 4'(i))) begin
                cnt_d[i] = CNT_W'(RESULT_LAT);
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset_i) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Indices >= NREGS match no entry and so never report busy.
    always_comb begin
        busy_rs_o = 1'b0;
        busy_rt_o = 1'b0;
        busy_rd_o = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            pending_o[i] = (cnt_q[i] != '0);
            if (rs_idx_i == 4'(i)) busy_rs_o = pending_o[i];
            if (rt_idx_i == 4'(i)) busy_rt_o = pending_o[i];
            if (rd_idx_i == 4'(i)) busy_rd_o = pending_o[i];
        end
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - in-order issue controller: hazard stall/bubble decision and run/drain/halt sequencing
// Ports:
//   clk_i, reset_i, start_i                 clock, sync active-high reset, start pulse
//   id_valid_i, id_op_i, id_rd/rs/rt_i      decoded instruction at the ID latch
//   issue_o, stall_o, bubble_o              combinational issue decision
//   pc_clear_o                              one-cycle PC reset pulse on entering RUN
//   busy_o, done_o                          RUN/DRAIN and HALTED state flags
//   sb_pending_o                            registers with a result in flight
//   stall_cnt_o                             saturating stall-cycle count for this run
//   err_o                                   sticky illegal opcode / bad register index
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int NREGS      = NREGS_DEF,
    parameter int RESULT_LAT = 2,
    parameter int CNT_W      = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             id_valid_i,
    input  logic [3:0]       id_op_i,
    input  logic [3:0]       id_rd_i,
    input  logic [3:0]       id_rs_i,
    input  logic [3:0]       id_rt_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             pc_clear_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [NREGS-1:0] sb_pending_o,
    output logic [15:0]      stall_cnt_o,
    output logic             err_o
);

    localparam logic [4:0] NREGS_L = 5'(NREGS);

    issue_state_e state_q, state_d;
    logic         pc_clear_q, pc_clear_d;
    logic [15:0]  stall_cnt_q, stall_cnt_d;
    logic         err_q, err_d;

    logic reads_src, writes_dst, op_legal, idx_bad, hazard;
    logic busy_rs, busy_rt, busy_rd;

    hazard_scoreboard #(
        .NREGS      (NREGS),
        .RESULT_LAT (RESULT_LAT),
        .CNT_W      (CNT_W)
    ) u_sb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (issue_o && writes_dst),
        .set_idx_i (id_rd_i),
        .rs_idx_i  (id_rs_i),
        .rt_idx_i  (id_rt_i),
        .rd_idx_i  (id_rd_i),
        .busy_rs_o (busy_rs),
        .busy_rt_o (busy_rt),
        .busy_rd_o (busy_rd),
        .pending_o (sb_pending_o)
    );

    // Illegal opcodes fall through with an empty read/write set, i.e. issue as NOP.
    always_comb begin
        reads_src  = (id_op_i == OP_ADD) || (id_op_i == OP_SUB);
        writes_dst = reads_src || (id_op_i == OP_LOAD);
        op_legal   = writes_dst || (id_op_i == OP_NOP) || (id_op_i == OP_HALT);
        idx_bad    = (reads_src && (({1'b0, id_rs_i} >= NREGS_L) || ({1'b0, id_rt_i} >= NREGS_L)))
                  || (writes_dst && ({1'b0, id_rd_i} >= NREGS_L));
        hazard     = (reads_src && (busy_rs || busy_rt)) || (writes_dst && busy_rd);
    end

    always_comb begin
        state_d    = state_q;
        pc_clear_d = 1'b0;
        issue_o    = 1'b0;
        stall_o    = 1'b1;
        bubble_o   = 1'b1;
        case (state_q)
            IDLE, HALTED: begin
                if (start_i) begin
                    state_d    = RUN;
                    pc_clear_d = 1'b1;
                end
            end
            RUN: begin
                stall_o = 1'b0;
                if (id_valid_i) begin
                    if (hazard) begin
                        stall_o = 1'b1;
                    end else begin
                        issue_o  = 1'b1;
                        bubble_o = 1'b0;
                        if (id_op_i == OP_HALT) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sb_pending_o == '0) state_d = HALTED;
            end
            default: state_d = IDLE;
        endcase
        // Keep the front end frozen and the scoreboard untouched while reset is held.
        if (reset_i) begin
            issue_o  = 1'b0;
            stall_o  = 1'b1;
            bubble_o = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_clear_d) begin
            stall_cnt_d = '0;
        end else if ((state_q == RUN) && stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        err_d = err_q || (issue_o && (!op_legal || idx_bad));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            pc_clear_q  <= 1'b0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_clear_q  <= pc_clear_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign pc_clear_o  = pc_clear_q;
    assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
    assign done_o      = (state_q == HALTED);
    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb/tb_pipe_issue_ctrl.sv - scoreboard bench for pipe_issue_ctrl with a ready-time reference model
module tb_pipe_issue_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset, start, id_valid;
    logic [3:0] id_op, id_rd, id_rs, id_rt;
    logic       issue_o, stall_o, bubble_o, pc_clear_o, busy_o, done_o, err_o;
    logic [7:0] sb_pending_o;
    logic [15:0] stall_cnt_o;

    pipe_issue_ctrl #(.NREGS(8), .RESULT_LAT(LAT), .CNT_W(2)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .id_valid_i   (id_valid),
        .id_op_i      (id_op),
        .id_rd_i      (id_rd),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .issue_o      (issue_o),
        .stall_o      (stall_o),
        .bubble_o     (bubble_o),
        .pc_clear_o   (pc_clear_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sb_pending_o (sb_pending_o),
        .stall_cnt_o  (stall_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         iss;
        bit         stl;
        bit         bub;
        logic [7:0] pend;
    } rec_t;

    rec_t q[$];
    rec_t mr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycle at which each register's result becomes readable.
    int free_at[8];
    int exp_stalls;
    bit exp_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pend_at(input int c);
        logic [7:0] p;
        for (int r = 0; r < 8; r++) p[r] = (free_at[r] > c);
        return p;
    endfunction

    task automatic push_rec(input int c, input bit iss, input bit stl, input bit bub, input logic [7:0] p);
        rec_t r;
        r.cyc = c; r.iss = iss; r.stl = stl; r.bub = bub; r.pend = p;
        q.push_back(r);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL stale_record: expected cycle %0d never observed, now %0d", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mr = q.pop_front();
            chk("issue", 32'(issue_o), 32'(mr.iss));
            chk("stall", 32'(stall_o), 32'(mr.stl));
            chk("bubble", 32'(bubble_o), 32'(mr.bub));
            chk("sb_pending", 32'(sb_pending_o), 32'(mr.pend));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge; presents one instruction until the model says it issues.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        int  c0 = cyc;
        int  t  = cyc;
        bit  reads  = (op == 4'h2) || (op == 4'h3);
        bit  writes = reads || (op == 4'h1);
        bit  legal  = writes || (op == 4'h0) || (op == 4'hF);
        if (reads) begin
            if (rs < 8 && free_at[rs] > t) t = free_at[rs];
            if (rt < 8 && free_at[rt] > t) t = free_at[rt];
        end
        if (writes && rd < 8 && free_at[rd] > t) t = free_at[rd];
        for (int c = c0; c <= t; c++) push_rec(c, c == t, c != t, c != t, pend_at(c));
        exp_stalls += t - c0;
        if (!legal || (reads && (rs >= 8 || rt >= 8)) || (writes && rd >= 8)) exp_err = 1'b1;
        if (writes && rd < 8) free_at[rd] = t + LAT + 1;
        id_valid = 1'b1; id_op = op; id_rd = rd; id_rs = rs; id_rt = rt;
        for (int c = c0; c <= t; c++) next_cycle();
        id_valid = 1'b0;
    endtask

    task automatic run_gap();
        push_rec(cyc, 1'b0, 1'b0, 1'b1, pend_at(cyc));
        id_valid = 1'b0;
        id_op = 4'($urandom); id_rd = 4'($urandom); id_rs = 4'($urandom); id_rt = 4'($urandom);
        next_cycle();
    endtask

    task automatic run_halt();
        int c0 = cyc;
        int f  = cyc + 1;
        push_rec(c0, 1'b1, 1'b0, 1'b0, pend_at(c0));
        for (int r = 0; r < 8; r++) if (free_at[r] > f) f = free_at[r];
        for (int c = c0 + 1; c <= f + 2; c++) push_rec(c, 1'b0, 1'b1, 1'b1, pend_at(c));
        id_valid = 1'b1; id_op = 4'hF; id_rd = 4'($urandom); id_rs = 4'($urandom); id_rt = 4'($urandom);
        next_cycle();
        id_valid = 1'b0;
        while (cyc < f) next_cycle();
        chk("drain_done", 32'(done_o), 32'd0);
        chk("drain_busy", 32'(busy_o), 32'd1);
        next_cycle();
        chk("halted_done", 32'(done_o), 32'd1);
        chk("halted_busy", 32'(busy_o), 32'd0);
        next_cycle();
        next_cycle();
        chk("run_stall_cnt", 32'(stall_cnt_o), 32'(exp_stalls));
        chk("run_err", 32'(err_o), 32'(exp_err));
    endtask

    task automatic do_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        exp_stalls = 0;
        chk("pc_clear_pulse", 32'(pc_clear_o), 32'd1);
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_done", 32'(done_o), 32'd0);
        chk("start_stall_cnt", 32'(stall_cnt_o), 32'd0);
        next_cycle();
        chk("pc_clear_single", 32'(pc_clear_o), 32'd0);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) free_at[r] = 0;
        exp_stalls = 0;
        exp_err    = 1'b0;
    endtask

    task automatic run_random(input int n);
        int          sel;
        logic [3:0]  op;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                run_gap();
            end else begin
                sel = $urandom_range(0, 15);
                if (sel < 2)       op = 4'h0;
                else if (sel < 7)  op = 4'h1;
                else if (sel < 11) op = 4'h2;
                else if (sel < 14) op = 4'h3;
                else if (sel < 15) op = 4'($urandom_range(4, 14));
                else               op = 4'h2;
                run_instr(op,
                          ($urandom_range(0, 19) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                          ($urandom_range(0, 19) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                          ($urandom_range(0, 19) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)));
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; id_valid = 1'b0;
        id_op = 4'h0; id_rd = 4'h0; id_rs = 4'h0; id_rt = 4'h0;
        model_reset();
        next_cycle();
        chk("reset_issue", 32'(issue_o), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd1);
        chk("reset_bubble", 32'(bubble_o), 32'd1);
        next_cycle();
        reset = 1'b0; start = 1'b0;
        #1;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_pending", 32'(sb_pending_o), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_pc_clear", 32'(pc_clear_o), 32'd0);

        do_start();
        // RAW: LOAD R1 then ADD R3=R1+R2
        run_instr(4'h1, 4'd1, 4'd0, 4'd0);
        run_instr(4'h2, 4'd3, 4'd1, 4'd2);
        chk("raw_stall_cnt", 32'(stall_cnt_o), 32'd2);
        // independent instructions back to back
        run_instr(4'h1, 4'd1, 4'd0, 4'd0);
        run_instr(4'h1, 4'd2, 4'd0, 4'd0);
        run_instr(4'h3, 4'd4, 4'd7, 4'd6);
        chk("nohaz_stall_cnt", 32'(stall_cnt_o), 32'd2);
        // WAW on a fresh register
        run_instr(4'h1, 4'd6, 4'd0, 4'd0);
        run_instr(4'h1, 4'd6, 4'd0, 4'd0);
        chk("waw_stall_cnt", 32'(stall_cnt_o), 32'd4);
        // out-of-range source register
        run_instr(4'h2, 4'd3, 4'd9, 4'd2);
        chk("bad_idx_err", 32'(err_o), 32'd1);
        run_random(150);
        run_halt();

        // restart, then LOAD R5 / HALT drain sequence
        do_start();
        run_instr(4'h1, 4'd5, 4'd0, 4'd0);
        run_halt();

        do_start();
        model_reset();
        run_random(60);
        run_instr(4'h2, 4'd3, 4'd9, 4'd2);
        chk("err_sticky", 32'(err_o), 32'd1);
        run_instr(4'h1, 4'd1, 4'd0, 4'd0);
        // reset while an ADD is stalled on R1
        id_valid = 1'b1; id_op = 4'h2; id_rd = 4'd3; id_rs = 4'd1; id_rt = 4'd2;
        #1;
        chk("midstall_stall", 32'(stall_o), 32'd1);
        chk("midstall_issue", 32'(issue_o), 32'd0);
        next_cycle();
        reset = 1'b1;
        #1;
        chk("in_reset_issue", 32'(issue_o), 32'd0);
        chk("in_reset_stall", 32'(stall_o), 32'd1);
        next_cycle();
        reset = 1'b0; id_valid = 1'b0;
        model_reset();
        chk("post_reset_busy", 32'(busy_o), 32'd0);
        chk("post_reset_done", 32'(done_o), 32'd0);
        chk("post_reset_pending", 32'(sb_pending_o), 32'd0);
        chk("post_reset_err", 32'(err_o), 32'd0);
        chk("post_reset_stall_cnt", 32'(stall_cnt_o), 32'd0);

        next_cycle();
        next_cycle();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
